// File: rtl/cpu_pkg.sv
// Shared types and default widths for the MEM pipeline stage.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int PC_W   = 5;
  localparam int REG_W  = 5;
  localparam int JT_W   = 3;

  // IDLE accepts a new instruction; ACCESS waits for the data memory ack.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: takes one EX/MEM instruction per cycle, runs loads and
// stores over a req/ack data-memory handshake, stalls upstream while an access
// is outstanding and registers the result into the MEM/WB outputs.
// Optional build macro MEM_ALIGN_CHECK_EN: memory ops whose byte address is
// not word aligned are not issued; they retire in one cycle with register
// write suppressed and a misalign_err pulse.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int PC_W   = cpu_pkg::PC_W,
  parameter int REG_W  = cpu_pkg::REG_W,
  parameter int JT_W   = cpu_pkg::JT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [JT_W-1:0]   in_jump_type,
  input  logic              in_reg_wrenable,
  input  logic [REG_W-1:0]  in_write_reg,
  input  logic              in_mem_wrenable,
  input  logic              in_mem_to_reg,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [PC_W-1:0]   wb_pc,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_wrenable,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [JT_W-1:0]   wb_jump_type,
  output logic              misalign_err
);

  state_t state_q;

  // Instruction captured when an access is issued; upstream may move on
  // only after ack, but WB is built from these copies regardless.
  logic [PC_W-1:0]   hold_pc_q;
  logic [DATA_W-1:0] hold_alu_q;
  logic [JT_W-1:0]   hold_jt_q;
  logic              hold_reg_we_q;
  logic [REG_W-1:0]  hold_wreg_q;
  logic              hold_load_q;

  logic              req_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              wb_valid_q;
  logic [PC_W-1:0]   wb_pc_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_reg_we_q;
  logic [REG_W-1:0]  wb_wreg_q;
  logic [JT_W-1:0]   wb_jt_q;
  logic              misalign_q;

  logic mem_op;
  logic misaligned;
  logic issue;

  assign mem_op = in_valid & (in_mem_to_reg | in_mem_wrenable);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |in_alu_res[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned op (checked build only) is retired like an ALU op instead.
  assign issue = mem_op & ~misaligned;

  // Upstream holds while a memory op is being issued or is still awaiting ack.
  assign stall = (state_q == IDLE) ? issue : ~dmem_ack;

  // Stage FSM with hold, memory-interface and writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_pc_q     <= '0;
      hold_alu_q    <= '0;
      hold_jt_q     <= '0;
      hold_reg_we_q <= 1'b0;
      hold_wreg_q   <= '0;
      hold_load_q   <= 1'b0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wb_valid_q    <= 1'b0;
      wb_pc_q       <= '0;
      wb_data_q     <= '0;
      wb_reg_we_q   <= 1'b0;
      wb_wreg_q     <= '0;
      wb_jt_q       <= '0;
      misalign_q    <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            hold_pc_q     <= in_pc;
            hold_alu_q    <= in_alu_res;
            hold_jt_q     <= in_jump_type;
            hold_reg_we_q <= in_reg_wrenable;
            hold_wreg_q   <= in_write_reg;
            // A store that also claims mem_to_reg is treated purely as a store.
            hold_load_q   <= in_mem_to_reg & ~in_mem_wrenable;
            req_q         <= 1'b1;
            we_q          <= in_mem_wrenable;
            addr_q        <= {in_alu_res[DATA_W-1:2], 2'b00};
            wdata_q       <= in_write_data;
            wb_valid_q    <= 1'b0;
            wb_reg_we_q   <= 1'b0;
            state_q       <= ACCESS;
          end else if (in_valid) begin
            wb_valid_q  <= 1'b1;
            wb_pc_q     <= in_pc;
            wb_data_q   <= in_alu_res;
            wb_reg_we_q <= in_reg_wrenable & ~(mem_op & misaligned);
            wb_wreg_q   <= in_write_reg;
            wb_jt_q     <= in_jump_type;
            misalign_q  <= mem_op & misaligned;
          end else begin
            wb_valid_q  <= 1'b0;
            wb_reg_we_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            wb_valid_q  <= 1'b1;
            wb_pc_q     <= hold_pc_q;
            wb_data_q   <= hold_load_q ? dmem_rdata : hold_alu_q;
            wb_reg_we_q <= hold_reg_we_q;
            wb_wreg_q   <= hold_wreg_q;
            wb_jt_q     <= hold_jt_q;
            state_q     <= IDLE;
          end else begin
            wb_valid_q  <= 1'b0;
            wb_reg_we_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign wb_valid        = wb_valid_q;
  assign wb_pc           = wb_pc_q;
  assign wb_data         = wb_data_q;
  assign wb_reg_wrenable = wb_reg_we_q;
  assign wb_write_reg    = wb_wreg_q;
  assign wb_jump_type    = wb_jt_q;
  assign misalign_err    = misalign_q;

endmodule
